// File: rtl/mem_slave_responder.sv
// Memory-side responder for the AS_N/WR_N/ACK_N bus handshake with run-time wait states and an idle-time host load port.
// Optional macro SLAVE_PIPE_OUT_EN adds one read-path output register stage (ACK_N and DOUT one cycle later).
module mem_slave_responder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WS_W   = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AS_N,
  input  logic              WR_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  input  logic [WS_W-1:0]   WAIT_CNT,
  input  logic              LD_WE,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              ACK_N,
  output logic [DATA_W-1:0] DOUT,
  output logic              BUSY,
  output logic              LD_REJ,
  output logic [1:0]        STATE_o
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WS_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_n_q;
  logic [DATA_W-1:0]   din_q;
  logic                take_c;
  logic                drained_c;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_wa_c;
  logic [DATA_W-1:0]   mem_wd_c;

  logic                ack_n_q, ack_n_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                ld_rej_q, ld_rej_d;

`ifdef SLAVE_PIPE_OUT_EN
  logic                ack_p_n_q, ack_p_n_d;
  logic [DATA_W-1:0]   rd_p_q, rd_p_d;
  logic                rd_vld_p_q, rd_vld_p_d;
  assign drained_c = ack_p_n_q;
`else
  assign drained_c = 1'b1;
`endif

  // State register plus the access latched when a strobe is taken.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_n_q  <= 1'b1;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take_c) begin
        addr_q <= ADDR;
        wr_n_q <= WR_N;
        din_q  <= DIN;
      end
    end
  end

  // Next state; a host load in IDLE defers the bus strobe by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!AS_N && !LD_WE) begin
          take_c = 1'b1;
          if (WAIT_CNT != '0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_CNT;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - WS_W'(1);
        if (cnt_q == WS_W'(1)) state_d = S_ACK;
      end
      S_ACK:     state_d = S_RECOVER;
      S_RECOVER: if (AS_N && drained_c) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output next values and the single array write port.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    ld_rej_d = LD_WE && (state_q != S_IDLE);
    mem_we_c = 1'b0;
    mem_wa_c = LD_ADDR;
    mem_wd_c = LD_DATA;
    dout_d   = dout_q;
    if (state_q == S_IDLE && LD_WE) begin
      mem_we_c = 1'b1;
    end else if (state_q == S_ACK && !wr_n_q) begin
      mem_we_c = 1'b1;
      mem_wa_c = addr_q;
      mem_wd_c = din_q;
    end
`ifdef SLAVE_PIPE_OUT_EN
    ack_p_n_d  = (state_q != S_ACK);
    rd_p_d     = rd_p_q;
    rd_vld_p_d = (state_q == S_ACK) && wr_n_q;
    if (state_q == S_ACK && wr_n_q) rd_p_d = mem_q[addr_q];
    ack_n_d    = ack_p_n_q;
    if (rd_vld_p_q) dout_d = rd_p_q;
`else
    ack_n_d = (state_q != S_ACK);
    if (state_q == S_ACK && wr_n_q) dout_d = mem_q[addr_q];
`endif
  end

  // Registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ack_n_q  <= 1'b1;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      ld_rej_q <= 1'b0;
`ifdef SLAVE_PIPE_OUT_EN
      ack_p_n_q  <= 1'b1;
      rd_p_q     <= '0;
      rd_vld_p_q <= 1'b0;
`endif
    end else begin
      ack_n_q  <= ack_n_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      ld_rej_q <= ld_rej_d;
`ifdef SLAVE_PIPE_OUT_EN
      ack_p_n_q  <= ack_p_n_d;
      rd_p_q     <= rd_p_d;
      rd_vld_p_q <= rd_vld_p_d;
`endif
    end
  end

  // Word array is never cleared; reset only suppresses a pending commit.
  always_ff @(posedge CLK) begin
    if (!RESET && mem_we_c) mem_q[mem_wa_c] <= mem_wd_c;
  end

  assign ACK_N   = ack_n_q;
  assign DOUT    = dout_q;
  assign BUSY    = busy_q;
  assign LD_REJ  = ld_rej_q;
  assign STATE_o = state_q;

endmodule

// File: tb/tb_mem_slave_responder.sv
// Self-checking bench for mem_slave_responder: bus master model, reference word array and read-data scoreboard.
module tb_mem_slave_responder;

`ifdef SLAVE_PIPE_OUT_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AS_N = 1'b1;
  logic        WR_N = 1'b1;
  logic [7:0]  ADDR = '0;
  logic [31:0] DIN = '0;
  logic [3:0]  WAIT_CNT = '0;
  logic        LD_WE = 1'b0;
  logic [7:0]  LD_ADDR = '0;
  logic [31:0] LD_DATA = '0;
  logic        ACK_N;
  logic [31:0] DOUT;
  logic        BUSY;
  logic        LD_REJ;
  logic [1:0]  STATE_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [256];
  logic [31:0] exp_q [$];

  mem_slave_responder #(.DATA_W(32), .ADDR_W(8), .WS_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .AS_N(AS_N), .WR_N(WR_N), .ADDR(ADDR), .DIN(DIN),
    .WAIT_CNT(WAIT_CNT), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .ACK_N(ACK_N), .DOUT(DOUT), .BUSY(BUSY), .LD_REJ(LD_REJ), .STATE_o(STATE_o)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [7:0] a, input logic [31:0] d);
    LD_WE = 1'b1; LD_ADDR = a; LD_DATA = d;
    step();
    LD_WE = 1'b0;
    model[a] = d;
  endtask

  // One master access; lat counts edges from the strobe-sampling edge up to and including the ACK edge.
  task automatic access(input logic wr_n, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] w, input int rej_at,
                        output int lat, output logic [31:0] dout_seen, output bit busy_ok,
                        output logic ack_after, output int rej_cnt, output bit timeout);
    if (wr_n) exp_q.push_back(model[a]);
    else model[a] = d;
    AS_N = 1'b0; WR_N = wr_n; ADDR = a; DIN = d; WAIT_CNT = w;
    lat = 0; busy_ok = 1'b1; rej_cnt = 0; timeout = 1'b1; dout_seen = '0; ack_after = 1'bx;
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      ADDR = ~a; DIN = ~d;
      LD_WE = (lat == rej_at);
      LD_ADDR = 8'h30; LD_DATA = 32'h0BAD0BAD;
      if (LD_REJ === 1'b1) rej_cnt++;
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      if (ACK_N === 1'b0) begin
        timeout = 1'b0;
        break;
      end
    end
    LD_WE = 1'b0;
    dout_seen = DOUT;
    step();
    ack_after = ACK_N;
    AS_N = 1'b1; WR_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (STATE_o === 2'd0) break;
      if (i == 9) timeout = 1'b1;
    end
  endtask

  task automatic check_access(input string tag, input logic wr_n, input int w_exp, input int lat,
                              input logic [31:0] dout_seen, input bit busy_ok,
                              input logic ack_after, input bit timeout);
    logic [31:0] exp_d;
    checks++;
    if (timeout) begin failures++; $display("FAIL %s timeout waiting for ACK_N/IDLE", tag); end
    checks++;
    if (lat - 1 !== w_exp + 1 + PIPE) begin
      failures++; $display("FAIL %s latency got=%0d exp=%0d", tag, lat - 1, w_exp + 1 + PIPE);
    end
    checks++;
    if (ack_after !== 1'b1) begin failures++; $display("FAIL %s ack_width ACK_N after pulse got=%b exp=1", tag, ack_after); end
    checks++;
    if (!busy_ok) begin failures++; $display("FAIL %s busy BUSY dropped got=0 exp=1", tag); end
    if (wr_n) begin
      exp_d = exp_q.pop_front();
      checks++;
      if (dout_seen !== exp_d) begin failures++; $display("FAIL %s dout got=%h exp=%h", tag, dout_seen, exp_d); end
    end
  endtask

  int lat, rej; logic [31:0] ds; bit bok, tmo; logic aa;

  task automatic test_reset();
    RESET = 1'b1;
    step(); step();
    checks++; if (ACK_N !== 1'b1) begin failures++; $display("FAIL reset_ack got=%b exp=1", ACK_N); end
    checks++; if (DOUT !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", DOUT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    checks++; if (STATE_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", STATE_o); end
    checks++; if (LD_REJ !== 1'b0) begin failures++; $display("FAIL reset_ldrej got=%b exp=0", LD_REJ); end
    RESET = 1'b0;
    step();
  endtask

  task automatic test_load_read();
    do_load(8'h05, 32'hDEADBEEF);
    access(1'b1, 8'h05, 32'h0, 4'd0, -1, lat, ds, bok, aa, rej, tmo);
    check_access("load_read", 1'b1, 0, lat, ds, bok, aa, tmo);
    checks++; if (rej !== 0) begin failures++; $display("FAIL load_read_ldrej got=%0d exp=0", rej); end
  endtask

  task automatic test_write_read();
    access(1'b0, 8'h10, 32'hA5A5A5A5, 4'd3, -1, lat, ds, bok, aa, rej, tmo);
    check_access("write_w3", 1'b0, 3, lat, ds, bok, aa, tmo);
    access(1'b1, 8'h10, 32'h0, 4'd0, -1, lat, ds, bok, aa, rej, tmo);
    check_access("read_back_10", 1'b1, 0, lat, ds, bok, aa, tmo);
  endtask

  task automatic test_wait_sweep();
    int ws [3] = '{0, 1, 15};
    for (int i = 0; i < 3; i++) begin
      access(1'b1, 8'h05, 32'h0, 4'(ws[i]), -1, lat, ds, bok, aa, rej, tmo);
      check_access($sformatf("sweep_w%0d", ws[i]), 1'b1, ws[i], lat, ds, bok, aa, tmo);
    end
  endtask

  task automatic test_load_reject();
    do_load(8'h30, 32'hCAFE0001);
    access(1'b1, 8'h05, 32'h0, 4'd6, 2, lat, ds, bok, aa, rej, tmo);
    check_access("reject_read", 1'b1, 6, lat, ds, bok, aa, tmo);
    checks++; if (rej !== 1) begin failures++; $display("FAIL reject_pulse count got=%0d exp=1", rej); end
    access(1'b1, 8'h30, 32'h0, 4'd0, -1, lat, ds, bok, aa, rej, tmo);
    check_access("reject_readback", 1'b1, 0, lat, ds, bok, aa, tmo);
  endtask

  task automatic test_reset_mid();
    int lows = 0;
    do_load(8'h20, 32'h11111111);
    AS_N = 1'b0; WR_N = 1'b0; ADDR = 8'h20; DIN = 32'h99999999; WAIT_CNT = 4'd8;
    step(); step(); step();
    RESET = 1'b1;
    step();
    checks++; if (STATE_o !== 2'd0) begin failures++; $display("FAIL resetmid_state got=%0d exp=0", STATE_o); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL resetmid_busy got=%b exp=0", BUSY); end
    RESET = 1'b0; AS_N = 1'b1; WR_N = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (ACK_N === 1'b0) lows++;
    end
    checks++; if (lows !== 0) begin failures++; $display("FAIL resetmid_noack ack cycles got=%0d exp=0", lows); end
    access(1'b1, 8'h20, 32'h0, 4'd2, -1, lat, ds, bok, aa, rej, tmo);
    check_access("resetmid_readback", 1'b1, 2, lat, ds, bok, aa, tmo);
  endtask

  task automatic test_back_to_back();
    access(1'b0, 8'h40, 32'h0BADF00D, 4'd0, -1, lat, ds, bok, aa, rej, tmo);
    check_access("b2b_write", 1'b0, 0, lat, ds, bok, aa, tmo);
    access(1'b1, 8'h40, 32'h0, 4'd0, -1, lat, ds, bok, aa, rej, tmo);
    check_access("b2b_raw", 1'b1, 0, lat, ds, bok, aa, tmo);
    access(1'b0, 8'h40, 32'h12345678, 4'd2, -1, lat, ds, bok, aa, rej, tmo);
    check_access("b2b_write2", 1'b0, 2, lat, ds, bok, aa, tmo);
    access(1'b1, 8'h40, 32'h0, 4'd1, -1, lat, ds, bok, aa, rej, tmo);
    check_access("b2b_raw2", 1'b1, 1, lat, ds, bok, aa, tmo);
    checks++; if (DOUT !== 32'h12345678) begin failures++; $display("FAIL dout_hold got=%h exp=12345678", DOUT); end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_write_read();
    test_wait_sweep();
    test_load_reject();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
